seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Time-multiplexed display controller for an N-digit common-anode seven-segment display.
- Drives one shared seven_seg_decoder instance: one digit per time slot, active-low anode selects.
- Inserts an all-off blanking gap before each digit to prevent ghosting.
- Holds value/decimal-point/blank data in a shadow register that updates only at frame boundaries, so the display never tears.
- Sits between the register/counter logic that produces hex values and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
ON_CYCLES, 50000, clock cycles each digit is lit (>=1)
BLANK_CYCLES, 1000, clock cycles all anodes are off before each digit (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 forces display dark and restarts scan
load  in  1  single-cycle strobe: capture value_in/dp_in/blank_in
value_in  in  4*NUM_DIGITS  hex nibbles; digit i = value_in[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  in  NUM_DIGITS  per-digit force-blank, 1 = dark
lzb  in  1  leading-zero blanking enable (static level)
segs  out  7  active-low segments, decoder encoding
dp_n  out  1  active-low decimal point
an  out  NUM_DIGITS  active-low anode selects, at most one low
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (async, active-high) sets all outputs inactive: an all 1s, segs 7'h7F, dp_n 1, frame_done 0. It also clears the active and pending shadows to 0 (value 0, dp 0, blank 0), clears pending_valid, sets state BLANK, idx 0, and sets the slot counter to 0.
- Register state:
  - idx: current digit, 0..NUM_DIGITS-1.
  - Slot counter: ceil(log2(max(ON_CYCLES, BLANK_CYCLES))) bits.
  - State: BLANK or ON.
- FSM:
  - BLANK: an all 1s. segs/dp_n already present the data for digit idx. After BLANK_CYCLES cycles, go to ON and reset the counter.
  - ON: an[idx] is 0 unless digit idx is suppressed. After ON_CYCLES cycles, go to BLANK.
    - If idx < NUM_DIGITS-1: idx increments.
    - Otherwise: idx wraps to 0, frame_done pulses in the first BLANK cycle, and the frame-boundary update happens.
  - Frame length is NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES) cycles.
- Outputs:
  - segs, dp_n and an are all registered (no combinational path from inputs to pins).
  - segs/dp_n change only on BLANK entry, never while any anode is low.
- Suppression:
  - Digit i is suppressed if active blank[i] is 1, or it is a leading zero.
  - Leading zero (only when lzb=1): nibble i is 0, every higher nibble is 0, and i != 0. Digit 0 is never LZ-blanked.
  - A suppressed digit keeps its slot timing with the anode held high.
  - Its dp is still output on dp_n, but it is invisible because the anode is off.
- Load/update:
  - load copies the inputs into the pending shadow and sets pending_valid. A later load overwrites pending data (last load wins).
  - At frame boundary (ON->BLANK of idx NUM_DIGITS-1): if pending_valid, pending is copied to active and pending_valid is cleared.
  - load in the same cycle as the boundary: the inputs bypass directly to active, and pending_valid is left 0.
  - lzb is sampled live; it affects the next BLANK entry.
- en=0 (synchronous): next cycle state BLANK, idx 0, counter 0, an all 1s, frame_done 0. Shadow registers and load still operate.
  - en re-asserted: full BLANK_CYCLES gap, then digit 0.
- Reset mid-frame: immediate dark outputs; pending load lost.

Decomposition:
- Shared package holds:
  - Scan state enum {ST_BLANK, ST_ON}.
  - SEG_OFF = 7'h7F.
  - Anode-off helper constant, all 1s of width NUM_DIGITS.
- Sub-module: one instance of the team's existing seven_seg_decoder (4-bit digit in, 7-bit active-low segs out), fed by the active nibble mux for the next idx. Its output is registered into segs.
- No other sub-modules.

Test Plan:
Bench parameters: NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2 (frame = 24 cycles).
1. Reset, then load value_in=16'h12AF, dp_in=4'b0000, en=1. From the second frame after load, the per-slot sequence is:
   - an=1110 with segs=0001110 (F)
   - an=1101 with segs=0001000 (A)
   - an=1011 with segs=0100100 (2)
   - an=0111 with segs=1111001 (1)
   Each slot is 4 cycles with an=1111 for 2 cycles between; frame_done pulses once every 24 cycles.
2. Load 16'h1234 mid-frame, then 16'h5678 two cycles later. The display stays on the old value until the boundary, then shows 5678. The value 1234 never appears.
3. load asserted exactly on the boundary cycle with 16'hBEEF: digit 0 of the very next slot shows F (0001110), and pending_valid=0 afterwards.
4. lzb=1, value 16'h0005:
   - an[3], an[2], an[1] never go low; an[0] low shows 5 (0010010).
   - value 16'h0000: only digit 0 lit, showing 0 (1000000).
   - lzb=0: all four digits light.
5. blank_in=4'b0100, dp_in=4'b0001: an[2] stays high for its whole slot, and dp_n=0 during digit 0's slot.
6. Deassert en mid-ON of digit 2: next cycle an=1111 and stays dark. Re-assert: 2 blank cycles, then digit 0 lit. Async reset mid-ON: an=1111 and segs=7'h7F in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Anode widths are parameterised per instance, so the all-off pattern is kept at max width here.
package seven_seg_scanner_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    localparam int          MAX_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL = 8'hFF;

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_seg_decoder
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segs
);

    // Pure lookup; every code is listed so the default only guards X propagation.
    always_comb begin
        segs = SEG_OFF;
        case (digit)
            4'h0:    segs = 7'h40;
            4'h1:    segs = 7'h79;
            4'h2:    segs = 7'h24;
            4'h3:    segs = 7'h30;
            4'h4:    segs = 7'h19;
            4'h5:    segs = 7'h12;
            4'h6:    segs = 7'h02;
            4'h7:    segs = 7'h78;
            4'h8:    segs = 7'h00;
            4'h9:    segs = 7'h10;
            4'hA:    segs = 7'h08;
            4'hB:    segs = 7'h03;
            4'hC:    segs = 7'h46;
            4'hD:    segs = 7'h21;
            4'hE:    segs = 7'h06;
            4'hF:    segs = 7'h0E;
            default: segs = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver with per-digit blanking gap,
// frame-synchronous shadow update and optional leading-zero suppression.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic                      lzb,
    output logic [6:0]                segs,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    import seven_seg_scanner_pkg::*;

    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_OFF_ALL[NUM_DIGITS-1:0];
    localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_r, state_nx_s;
    logic [IDX_W-1:0]       idx_r, idx_nx_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
    logic                   blank_entry_s;
    logic                   light_s;
    logic                   boundary_s;

    logic [VAL_W-1:0]       act_val_r, act_val_nx_s;
    logic [NUM_DIGITS-1:0]  act_dp_r, act_dp_nx_s;
    logic [NUM_DIGITS-1:0]  act_blank_r, act_blank_nx_s;
    logic [VAL_W-1:0]       pend_val_r, pend_val_nx_s;
    logic [NUM_DIGITS-1:0]  pend_dp_r, pend_dp_nx_s;
    logic [NUM_DIGITS-1:0]  pend_blank_r, pend_blank_nx_s;
    logic                   pend_valid_r, pend_valid_nx_s;

    logic [NUM_DIGITS-1:0]  lz_mask_s;
    logic [3:0]             dig_nib_s;
    logic                   dig_dp_s;
    logic                   sup_nx_s;
    logic                   sup_r;
    logic [6:0]             dec_segs_s;
    logic [NUM_DIGITS-1:0]  an_sel_s;

    assign boundary_s = en && (state_r == ST_ON) && (cnt_r == ON_LAST) && (idx_r == IDX_LAST);

    // Slot sequencing: BLANK gap then ON for each digit; en low parks the scan at digit 0's gap.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        cnt_nx_s      = cnt_r + CNT_W'(1);
        blank_entry_s = 1'b0;
        light_s       = 1'b0;
        if (!en) begin
            state_nx_s    = ST_BLANK;
            idx_nx_s      = IDX_W'(0);
            cnt_nx_s      = CNT_W'(0);
            blank_entry_s = 1'b1;
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_nx_s = ST_ON;
                        cnt_nx_s   = CNT_W'(0);
                        light_s    = 1'b1;
                    end else begin
                        state_nx_s = ST_BLANK;
                    end
                end
                ST_ON: begin
                    if (cnt_r == ON_LAST) begin
                        state_nx_s    = ST_BLANK;
                        cnt_nx_s      = CNT_W'(0);
                        blank_entry_s = 1'b1;
                        if (idx_r == IDX_LAST) begin
                            idx_nx_s = IDX_W'(0);
                        end else begin
                            idx_nx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        state_nx_s = ST_ON;
                    end
                end
                default: begin
                    state_nx_s    = ST_BLANK;
                    idx_nx_s      = IDX_W'(0);
                    cnt_nx_s      = CNT_W'(0);
                    blank_entry_s = 1'b1;
                end
            endcase
        end
    end

    // Shadow update: a load on the boundary cycle bypasses straight to the active copy.
    always_comb begin
        act_val_nx_s    = act_val_r;
        act_dp_nx_s     = act_dp_r;
        act_blank_nx_s  = act_blank_r;
        pend_val_nx_s   = pend_val_r;
        pend_dp_nx_s    = pend_dp_r;
        pend_blank_nx_s = pend_blank_r;
        pend_valid_nx_s = pend_valid_r;
        if (boundary_s) begin
            if (load) begin
                act_val_nx_s   = value_in;
                act_dp_nx_s    = dp_in;
                act_blank_nx_s = blank_in;
            end else if (pend_valid_r) begin
                act_val_nx_s   = pend_val_r;
                act_dp_nx_s    = pend_dp_r;
                act_blank_nx_s = pend_blank_r;
            end else begin
                act_val_nx_s   = act_val_r;
            end
            pend_valid_nx_s = 1'b0;
        end else if (load) begin
            pend_val_nx_s   = value_in;
            pend_dp_nx_s    = dp_in;
            pend_blank_nx_s = blank_in;
            pend_valid_nx_s = 1'b1;
        end else begin
            pend_valid_nx_s = pend_valid_r;
        end
    end

    // Leading-zero mask from the data that will be active after this edge; digit 0 always shows.
    always_comb begin
        logic run_zero;
        run_zero  = 1'b1;
        lz_mask_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero & (act_val_nx_s[4*i +: 4] == 4'h0);
            lz_mask_s[i] = lzb & run_zero & (i != 0);
        end
    end

    // Digit mux for the slot about to start, plus the one-cold anode for the current slot.
    always_comb begin
        dig_nib_s = act_val_nx_s[{idx_nx_s, 2'b00} +: 4];
        dig_dp_s  = act_dp_nx_s[idx_nx_s];
        sup_nx_s  = act_blank_nx_s[idx_nx_s] | lz_mask_s[idx_nx_s];
        an_sel_s  = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_sel_s[i] = (IDX_W'(i) != idx_r);
        end
    end

    seven_seg_decoder u_decoder (
        .digit (dig_nib_s),
        .segs  (dec_segs_s)
    );

    // Scan state, slot counter and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_BLANK;
            idx_r   <= IDX_W'(0);
            cnt_r   <= CNT_W'(0);
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Active and pending display shadows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_val_r    <= {VAL_W{1'b0}};
            act_dp_r     <= {NUM_DIGITS{1'b0}};
            act_blank_r  <= {NUM_DIGITS{1'b0}};
            pend_val_r   <= {VAL_W{1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blank_r <= {NUM_DIGITS{1'b0}};
            pend_valid_r <= 1'b0;
        end else begin
            act_val_r    <= act_val_nx_s;
            act_dp_r     <= act_dp_nx_s;
            act_blank_r  <= act_blank_nx_s;
            pend_val_r   <= pend_val_nx_s;
            pend_dp_r    <= pend_dp_nx_s;
            pend_blank_r <= pend_blank_nx_s;
            pend_valid_r <= pend_valid_nx_s;
        end
    end

    // Pin registers: segment data only moves while every anode is off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segs       <= SEG_OFF;
            dp_n       <= 1'b1;
            an         <= AN_OFF;
            frame_done <= 1'b0;
            sup_r      <= 1'b0;
        end else begin
            frame_done <= boundary_s;
            if (blank_entry_s) begin
                segs  <= dec_segs_s;
                dp_n  <= ~dig_dp_s;
                sup_r <= sup_nx_s;
                an    <= AN_OFF;
            end else if (light_s) begin
                an <= sup_r ? AN_OFF : an_sel_s;
            end else begin
                an <= an;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised scoreboard bench: a cycle-position reference model predicts anodes,
// per-slot segment data and frame pulses; a negedge monitor compares.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int ONC   = 4;
    localparam int BLC   = 2;
    localparam int SLOT  = ONC + BLC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en, load, lzb;
    logic [15:0] value_in;
    logic [3:0]  dp_in, blank_in;
    logic [6:0]  segs;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    seven_seg_scanner #(.NUM_DIGITS(ND), .ON_CYCLES(ONC), .BLANK_CYCLES(BLC)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank_in(blank_in), .lzb(lzb), .segs(segs), .dp_n(dp_n),
        .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         stamp;
        logic [6:0] segs;
        logic       dp_n;
    } slot_t;

    int     total = 0;
    int     bad = 0;
    slot_t  exp_q[$];
    int     fd_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: n counts enabled edges since the scan (re)started.
    int          cyc = 0;
    int          n = 0;
    logic [15:0] m_val = 16'h0, p_val = 16'h0;
    logic [3:0]  m_dp = 4'h0, p_dp = 4'h0, m_bl = 4'h0, p_bl = 4'h0;
    logic        pv = 1'b0;
    logic [3:0]  m_an = 4'hF;
    slot_t       nxt;
    logic        nxt_sup = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    initial begin : model
        int d, lead;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                n = 0; m_val = 16'h0; m_dp = 4'h0; m_bl = 4'h0;
                p_val = 16'h0; p_dp = 4'h0; p_bl = 4'h0; pv = 1'b0;
                nxt.stamp = 0; nxt.segs = 7'h7F; nxt.dp_n = 1'b1; nxt_sup = 1'b0;
                m_an = 4'hF;
                exp_q.delete(); fd_q.delete();
            end else begin
                cyc++;
                if (!en) n = 0; else n = n + 1;
                if (en && (n % FRAME) == 0) begin
                    if (load) begin
                        m_val = value_in; m_dp = dp_in; m_bl = blank_in;
                    end else if (pv) begin
                        m_val = p_val; m_dp = p_dp; m_bl = p_bl;
                    end
                    pv = 1'b0;
                    fd_q.push_back(cyc);
                end else if (load) begin
                    p_val = value_in; p_dp = dp_in; p_bl = blank_in; pv = 1'b1;
                end
                d = (n / SLOT) % ND;
                if ((n % SLOT) == 0) begin
                    lead = 0;
                    for (int k = 0; k < ND; k++) if ((m_val >> (4 * k)) != 16'h0) lead = k;
                    nxt.segs = seg_tab[(m_val >> (4 * d)) & 16'hF];
                    nxt.dp_n = ~m_dp[d];
                    nxt_sup  = m_bl[d] || (lzb && d > lead);
                end
                if ((n % SLOT) == BLC && !nxt_sup) begin
                    nxt.stamp = cyc;
                    exp_q.push_back(nxt);
                end
                if ((n % SLOT) >= BLC && !nxt_sup) m_an = ~(4'b0001 << d);
                else m_an = 4'hF;
            end
        end
    end

    initial begin : monitor
        slot_t cur;
        logic  lit, exp_fd;
        lit = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("anodes", 32'(an), 32'(m_an));
                exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
                if (exp_fd) void'(fd_q.pop_front());
                chk("frame_done", 32'(frame_done), 32'(exp_fd));
                if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                    cur = exp_q.pop_front();
                    lit = 1'b1;
                end else if (m_an == 4'hF) begin
                    lit = 1'b0;
                end
                if (lit) begin
                    chk("slot_segs", 32'(segs), 32'(cur.segs));
                    chk("slot_dp_n", 32'(dp_n), 32'(cur.dp_n));
                end
            end else begin
                lit = 1'b0;
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value_in = v; dp_in = dp; blank_in = bl; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while ((n % FRAME) != ph && k < 200) begin
            @(negedge clk);
            k++;
        end
        if ((n % FRAME) != ph) chk("wait_phase", 32'(n % FRAME), 32'(ph));
    endtask

    initial begin : stim
        logic [31:0] r;
        int k;
        en = 1'b0; load = 1'b0; lzb = 1'b0;
        value_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        #1 reset = 1'b1;
        #2;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_segs", 32'(segs), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'h1);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic scan of 12AF
        do_load(16'h12AF, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (3 * FRAME) @(negedge clk);

        // Last load before the boundary wins
        wait_phase(5);
        do_load(16'h1234, 4'b0000, 4'b0000);
        @(negedge clk);
        do_load(16'h5678, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        // Load exactly on the boundary edge bypasses to active
        wait_phase(FRAME - 1);
        do_load(16'hBEEF, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        // Leading-zero blanking
        lzb = 1'b1;
        do_load(16'h0005, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0000, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);
        lzb = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        // Forced blank on digit 2, dp on digit 0
        do_load(16'h9C3D, 4'b0001, 4'b0100);
        repeat (2 * FRAME) @(negedge clk);

        // Randomised traffic with en drops and lzb toggles
        for (int c = 0; c < 400; c++) begin
            r = $urandom;
            case ($urandom_range(3))
                0:       value_in = r[15:0];
                1:       value_in = {8'h00, r[7:0]};
                2:       value_in = {12'h000, r[3:0]};
                default: value_in = 16'h0000;
            endcase
            r = $urandom;
            dp_in    = r[3:0];
            blank_in = ($urandom_range(3) == 0) ? r[7:4] : 4'h0;
            load     = ($urandom_range(7) == 0);
            if ($urandom_range(40) == 0) lzb = ~lzb;
            if (en && $urandom_range(80) == 0) en = 1'b0;
            else if (!en && $urandom_range(2) == 0) en = 1'b1;
            @(negedge clk);
        end
        load = 1'b0;
        en = 1'b1;
        lzb = 1'b0;
        do_load(16'h4321, 4'b0000, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);

        // en dropped during digit 2's ON time, then restarted
        wait_phase(2 * SLOT + BLC + 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_dark", 32'(an), 32'hF);
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        chk("slot_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("frame_queue_drained", 32'(fd_q.size()), 32'h0);

        // Asynchronous reset while a digit is lit
        k = 0;
        while (an == 4'hF && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("lit_before_reset", 32'(an != 4'hF), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_segs", 32'(segs), 32'h7F);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
